// File: rtl/filtered_pixel_packer.sv
// rtl/filtered_pixel_packer.sv - packs a 24-bit pixel stream into framed 32-bit words
// behind a first-word-fall-through FIFO with ready/valid output.
module filtered_pixel_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        data_valid_in,
  input  logic [DATA_WIDTH*3-1:0]     data_in,
  input  logic [15:0]                 width,
  input  logic [15:0]                 high,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_data,
  output logic [3:0]                  out_keep,
  output logic                        out_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t      state, state_n;
  logic [1:0]  phase, phase_n;
  logic [23:0] acc, acc_n;
  logic [31:0] px_cnt, px_cnt_n;
  logic [31:0] frame_px, frame_px_n;
  logic        push;
  logic [36:0] push_entry;
  logic [23:0] px;
  logic [31:0] size_now;

  assign px       = data_in[23:0];
  assign size_now = {16'd0, width} * {16'd0, high};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= 2'd0;
      acc      <= 24'd0;
      px_cnt   <= 32'd0;
      frame_px <= 32'd0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      acc      <= acc_n;
      px_cnt   <= px_cnt_n;
      frame_px <= frame_px_n;
    end
  end

  always_comb begin
    logic [31:0] word;
    logic        frame_end;
    state_n    = state;
    phase_n    = phase;
    acc_n      = acc;
    px_cnt_n   = px_cnt;
    frame_px_n = frame_px;
    push       = 1'b0;
    push_entry = '0;
    word       = '0;
    frame_end  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (data_valid_in) begin
            frame_px_n = size_now;
            px_cnt_n   = 32'd1;
            acc_n      = px;
            phase_n    = 2'd3;
            state_n    = (size_now == 32'd1) ? FLUSH : ACTIVE;
          end
        end
        ACTIVE: begin
          if (data_valid_in) begin
            px_cnt_n  = px_cnt + 32'd1;
            frame_end = (px_cnt_n == frame_px);
            case (phase)
              2'd0: begin
                acc_n   = px;
                phase_n = 2'd3;
              end
              2'd3: begin
                word    = {px[7:0], acc[23:0]};
                acc_n   = {8'd0, px[23:8]};
                phase_n = 2'd2;
                push    = 1'b1;
              end
              2'd2: begin
                word    = {px[15:0], acc[15:0]};
                acc_n   = {16'd0, px[23:16]};
                phase_n = 2'd1;
                push    = 1'b1;
              end
              default: begin
                word    = {px, acc[7:0]};
                acc_n   = 24'd0;
                phase_n = 2'd0;
                push    = 1'b1;
              end
            endcase
            push_entry = {frame_end && (phase_n == 2'd0), 4'hF, word};
            if (frame_end) state_n = FLUSH;
          end
        end
        FLUSH: begin
          // Residual bytes go out now; a simultaneous pixel only fills a fresh accumulator.
          case (phase)
            2'd1:    begin push = 1'b1; push_entry = {1'b1, 4'b0001, 24'd0, acc[7:0]};  end
            2'd2:    begin push = 1'b1; push_entry = {1'b1, 4'b0011, 16'd0, acc[15:0]}; end
            2'd3:    begin push = 1'b1; push_entry = {1'b1, 4'b0111, 8'd0, acc[23:0]};  end
            default: ;
          endcase
          phase_n = 2'd0;
          acc_n   = 24'd0;
          state_n = IDLE;
          if (data_valid_in) begin
            frame_px_n = size_now;
            px_cnt_n   = 32'd1;
            acc_n      = px;
            phase_n    = 2'd3;
            state_n    = (size_now == 32'd1) ? FLUSH : ACTIVE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [36:0]   head;
  logic          pop, full, wr_en;

  assign head  = mem[rd_ptr];
  assign pop   = out_valid && out_ready;
  assign full  = (count == FULL_LVL);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      frame_done <= pop && head[36];
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head[31:0]  : 32'd0;
  assign out_keep   = out_valid ? head[35:32] : 4'd0;
  assign out_last   = out_valid ? head[36]    : 1'b0;
  assign fifo_level = count;

endmodule

// File: tb/tb_filtered_pixel_packer.sv
// tb/tb_filtered_pixel_packer.sv - self-checking bench for filtered_pixel_packer
// against a byte-queue reference model.
module tb_filtered_pixel_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, enable, data_valid_in, out_ready;
  logic [23:0] data_in;
  logic [15:0] width, high;
  logic        out_valid, out_last, overflow, frame_done;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [$clog2(DEPTH):0] fifo_level;

  filtered_pixel_packer #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_valid_in(data_valid_in),
    .data_in(data_in), .width(width), .high(high), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [36:0] exp_q[$];
  logic [36:0] popped[$];
  logic [7:0]  m_bytes[$];
  longint      m_left = 0;
  logic        fd_exp = 1'b0;
  int          fd_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame = byte stream chopped into 4-byte words; the tail is zero-padded and marked last.
  task automatic model_pixel(input logic [23:0] p, input logic [15:0] w, input logic [15:0] h);
    logic [31:0] d;
    logic        lst;
    int          n;
    if (m_left == 0) begin
      m_left = longint'(w) * longint'(h);
      if (m_left == 0) m_left = 64'd1 << 32;
    end
    m_bytes.push_back(p[7:0]);
    m_bytes.push_back(p[15:8]);
    m_bytes.push_back(p[23:16]);
    m_left--;
    while (m_bytes.size() >= 4) begin
      d = '0;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = m_bytes.pop_front();
      lst = (m_left == 0) && (m_bytes.size() == 0);
      exp_q.push_back({lst, 4'hF, d});
    end
    if (m_left == 0 && m_bytes.size() > 0) begin
      n = m_bytes.size();
      d = '0;
      for (int k = 0; k < n; k++) d[8*k +: 8] = m_bytes[k];
      exp_q.push_back({1'b1, 4'((1 << n) - 1), d});
      m_bytes.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_bytes.delete();
    m_left = 0;
  endtask

  task automatic observe();
    logic [36:0] got;
    check("frame_done", frame_done, fd_exp);
    if (frame_done) fd_count++;
    if (!out_valid) check("idle_zero", {out_last, out_keep, out_data}, 0);
    fd_exp = 1'b0;
    if (!rst && out_valid && out_ready) begin
      got = {out_last, out_keep, out_data};
      popped.push_back(got);
      check("pop_has_expect", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("pop_word", got, exp_q.pop_front());
      fd_exp = out_last;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_valid_in = 1'b0;
    data_in = 24'($urandom);
    repeat (n) step();
  endtask

  task automatic drive_px(input logic [23:0] p);
    data_valid_in = 1'b1;
    data_in = p;
    if (enable && !rst) model_pixel(p, width, high);
    step();
    data_valid_in = 1'b0;
  endtask

  task automatic exact_fit(input string tag);
    int fd0;
    width = 16'd4; high = 16'd1; out_ready = 1'b1; enable = 1'b1;
    fd0 = fd_count;
    popped.delete();
    drive_px(24'h030201);
    drive_px(24'h060504);
    check({tag, "_lat"}, out_valid, 1);
    drive_px(24'h090807);
    drive_px(24'h0C0B0A);
    idle(6);
    check({tag, "_cnt"}, popped.size(), 3);
    if (popped.size() == 3) begin
      check({tag, "_w0"}, popped[0], {1'b0, 4'hF, 32'h04030201});
      check({tag, "_w1"}, popped[1], {1'b0, 4'hF, 32'h08070605});
      check({tag, "_w2"}, popped[2], {1'b1, 4'hF, 32'h0C0B0A09});
    end
    check({tag, "_fd"}, fd_count - fd0, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; data_valid_in = 1'b1; data_in = 24'h123456;
    width = 16'd4; high = 16'd1; out_ready = 1'b1;
    step();
    data_in = 24'h654321;
    step();
    rst = 1'b0;
    data_valid_in = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_keep", out_keep, 0);
    check("rst_last", out_last, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fd", frame_done, 0);
    model_reset();
    idle(2);

    exact_fit("exact");

    // single-pixel frame: flush word appears one cycle after the pixel
    width = 16'd1; high = 16'd1;
    drive_px(24'hAABBCC);
    check("sp_lat0", out_valid, 0);
    step();
    check("sp_lat1", out_valid, 1);
    check("sp_word", {out_last, out_keep, out_data}, {1'b1, 4'b0111, 32'h00AABBCC});
    idle(4);

    // back-to-back 5-pixel frames
    width = 16'd5; high = 16'd1;
    popped.delete();
    for (int i = 1; i <= 10; i++) drive_px(24'(i));
    idle(10);
    check("b2b_cnt", popped.size(), 8);
    if (popped.size() == 8) begin
      check("b2b_flush", popped[3], {1'b1, 4'b0111, 32'h00000005});
      check("b2b_next", popped[4], {1'b0, 4'hF, 32'h07000006});
    end
    check("b2b_drained", exp_q.size(), 0);

    // overflow with a stalled consumer
    out_ready = 1'b0;
    width = 16'd8; high = 16'd1;
    for (int i = 1; i <= 8; i++) begin
      drive_px(24'($urandom));
      if (i == 6) begin
        check("ovf_lvl6", fifo_level, 4);
        check("ovf_flag6", overflow, 0);
      end
      if (i >= 7) begin
        check("ovf_lvl", fifo_level, 4);
        check("ovf_flag", overflow, 1);
      end
    end
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    popped.delete();
    out_ready = 1'b1;
    idle(8);
    check("ovf_drain_cnt", popped.size(), 4);
    check("ovf_sticky", overflow, 1);
    check("ovf_level0", fifo_level, 0);
    check("ovf_drained", exp_q.size(), 0);

    rst = 1'b1;
    model_reset();
    idle(1);
    rst = 1'b0;
    check("ovf_clear", overflow, 0);

    // mid-frame reset then a clean frame
    width = 16'd4; high = 16'd1;
    drive_px(24'h111111);
    drive_px(24'h222222);
    rst = 1'b1;
    model_reset();
    idle(1);
    rst = 1'b0;
    exact_fit("mid_rst");

    // randomized traffic, never overfilling the FIFO
    for (int c = 0; c < 1500; c++) begin
      width     = 16'($urandom_range(1, 6));
      high      = 16'($urandom_range(1, 2));
      out_ready = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 9) != 0);
      if (fifo_level <= 1 && $urandom_range(0, 1) == 1) drive_px(24'($urandom));
      else idle(1);
    end
    enable = 1'b1;
    out_ready = 1'b1;
    idle(20);
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_level", fifo_level, 0);
    check("rnd_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filtered_pixel_packer.md
# filtered_pixel_packer

Downstream stage of the filter system. Consumes the 24-bit filtered pixel stream (three 8-bit channels, one pixel per `data_valid_in` cycle), repacks it into a dense little-endian 32-bit word stream, and marks frame end with `out_last`/`out_keep`. A FIFO and a ready/valid handshake decouple the free-running pixel stream from a back-pressuring consumer such as a memory writer or an external interface.

## Interface
- `DATA_WIDTH`, 8, channel width; only 8 is supported (one byte per channel).
- `FIFO_DEPTH`, 16, output FIFO depth in words; a power of two, ≥ 2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  input-side enable; when low, `data_valid_in` is ignored and the output side keeps draining.
- `data_valid_in`  in  1  a pixel is present on `data_in`.
- `data_in`  in  DATA_WIDTH*3  pixel; byte 0 is `[7:0]`, byte 1 is `[15:8]`, byte 2 is `[23:16]`.
- `width`, `high`  in  16 each  frame dimensions; sampled on the first pixel of each frame.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head word.
- `out_data`  out  32  packed bytes; the earliest byte is in `[7:0]`.
- `out_keep`  out  4  byte-lane valid mask.
- `out_last`  out  1  final word of the frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag; set when a word is dropped because the FIFO is full.
- `frame_done`  out  1  one-cycle pulse when the word with `out_last` set is popped.

## Operation
- **Frame size:**
  - On the first accepted pixel in IDLE, register `frame_px = width*high` as a 32-bit value.
  - A product of 0 counts as 2^32, so `out_last` never fires for that frame.
- **FSM states:** IDLE, ACTIVE, FLUSH.
  - IDLE → ACTIVE on the first accepted pixel.
  - ACTIVE → FLUSH when the accepted pixel count equals `frame_px`.
  - FLUSH → IDLE after one cycle.
  - A frame of exactly one pixel goes IDLE → FLUSH directly.
- **Byte accumulator:** holds 0–3 bytes. `phase` (0..3) is the number of bytes held.
  - Each accepted pixel appends 3 bytes.
  - Phase transitions: 0→3 (no write); 3→2, 2→1, 1→0 (each writes one full word, `keep=4'hF`).
- **Last pixel of a frame:**
  - If the resulting phase is 0, the word written in that same cycle carries `last=1`.
  - Otherwise, the FLUSH cycle writes the remaining bytes zero-padded in the upper lanes, with `keep` = 4'b0001, 0011 or 0111 for 1, 2 or 3 bytes, and `last=1`. Phase then resets to 0.
- **Pixel arriving during FLUSH:** it is the first pixel of the next frame.
  - `width`/`high` are sampled again and the pixel count restarts at 1.
  - The pixel enters a fresh accumulator (phase 0→3), so at most one FIFO write happens per cycle.
  - The FSM goes FLUSH → ACTIVE, or FLUSH → FLUSH if the new frame is one pixel.
- **FIFO:**
  - Entries are {last, keep[3:0], data[31:0]}, organised as first-word-fall-through.
  - A pop happens when `out_valid && out_ready`.
  - A push when full with a simultaneous pop is accepted.
  - A push when full without a pop drops the word and sets `overflow`.
  - `fifo_level` is updated every cycle.
- **When `out_valid=0`:** `out_data`, `out_keep` and `out_last` are 0.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `out_last=0`, `fifo_level=0`, `overflow=0`, `frame_done=0`.
  - FSM is in IDLE, phase is 0, pixel count is 0.
  - `rst` during a frame discards the partial word and all FIFO contents.
- **Latency:**
  - A pixel sampled at edge k that completes a word makes `out_valid=1` after edge k.
  - A flush word is written at edge k+1 and visible after edge k+1.
- **Handshake:**
  - While `out_ready=0`, `out_data`, `out_keep` and `out_last` stay stable.
  - The consumer sees a new head the cycle after a pop.
- **`frame_done`:** high for the single cycle after the edge that pops the `out_last` word.
- **`enable` low:** accumulator, pixel count and FSM hold their values; FIFO pops continue.

## Test plan
- **Reset:** apply `rst` for 2 cycles with pixels driven → all outputs 0, `fifo_level=0`.
- **Exact-fit frame:** `width=4`, `high=1`, pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, `out_ready=1` → words 0x04030201, 0x08070605, 0x0C0B0A09, all with `keep=F`. Only the third has `last=1`. `frame_done` pulses once.
- **Single-pixel frame:** `width=1`, `high=1`, pixel 0xAABBCC → one word 0x00AABBCC, `keep=0111`, `last=1`, written one cycle after the pixel.
- **Back-to-back frames:** `width=5`, `high=1`, pixels 1..5 followed with no gap by the next frame's first pixel → 3 full words, then the flush word (`keep=0111`, `last=1`) in the FLUSH cycle. The next frame's bytes start a new word.
- **Overflow:** `FIFO_DEPTH=4`, `out_ready=0`, `width=8`, `high=1`, 8 pixels (6 words) → `fifo_level` saturates at 4 and `overflow=1` from the 5th word on. Raising `out_ready` drains the first 4 words in order; `overflow` stays 1.
- **Mid-frame reset:** `rst` after 2 pixels of a 4-pixel frame, then a fresh 4-pixel frame → no residue from the first frame; output matches the exact-fit case.
